// File: rtl/mmu_pkg.sv
// Shared geometry, TLB entry layout and MMU register bit positions for the
// vc16 second-generation MMU (split I/D fully associative TLBs).
package mmu_pkg;

    // Geometry: PAGE_BITS >= 4 + ASID_W, NTLB a power of 2 and >= 2, VA <= RV.
    localparam int RV        = 16;
    localparam int VA        = RV;
    localparam int PA        = RV;
    localparam int PAGE_BITS = VA - 3;
    localparam int NTLB      = 8;
    localparam int ASID_W    = 4;

    localparam int WB    = RV / 16;
    localparam int VPN_W = VA - PAGE_BITS;
    localparam int PPN_W = PA - PAGE_BITS;
    localparam int IDX_W = $clog2(NTLB);

    localparam int REG_ENTRY    = 0;
    localparam int REG_VALID    = 1;
    localparam int REG_PERM     = 2;
    localparam int REG_GLOBAL   = 3;
    localparam int REG_ASID_LSB = 4;
    localparam int REG_TYPE     = 1;
    localparam int REG_SUP      = 2;
    localparam int REG_INS      = 3;

    localparam int INV_UD = 0;
    localparam int INV_UI = 1;
    localparam int INV_SD = 2;
    localparam int INV_SI = 3;

    typedef logic [VPN_W-1:0]  vpn_t;
    typedef logic [PPN_W-1:0]  ppn_t;
    typedef logic [ASID_W-1:0] asid_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef struct packed {
        logic  valid;
        logic  sup;
        logic  glob;
        logic  perm;
        asid_t asid;
        vpn_t  vpn;
        ppn_t  ppn;
    } entry_t;

    typedef struct packed {
        vpn_t  vpn;
        asid_t asid;
        logic  ins;
        logic  sup;
        logic  miss;
    } fault_t;

    function automatic idx_t lowest_index(input logic [NTLB-1:0] vec);
        lowest_index = '0;
        for (int i = NTLB - 1; i >= 0; i--) begin
            if (vec[i]) lowest_index = idx_t'(i);
        end
    endfunction

endpackage

// File: rtl/tlb_bank.sv
// One fully associative TLB: combinational lookup with lowest-index priority,
// single-cycle invalidate, and refill into a matching tag or the round-robin slot.
module tlb_bank
    import mmu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  vpn_t  lookup_vpn,
    input  logic  lookup_sup,
    input  asid_t asid,
    output logic  hit,
    output ppn_t  hit_ppn,
    output logic  hit_perm,
    input  logic  inv_sup,
    input  logic  inv_user,
    input  logic  inv_asid_only,
    input  logic  refill,
    input  logic  refill_sup,
    input  vpn_t  refill_vpn,
    input  asid_t refill_asid,
    input  ppn_t  refill_ppn,
    input  logic  refill_valid,
    input  logic  refill_perm,
    input  logic  refill_glob
);

    entry_t           tlb [NTLB];
    idx_t             rr_ptr;
    logic [NTLB-1:0]  hit_vec;
    logic [NTLB-1:0]  tag_vec;
    idx_t             hit_idx;
    idx_t             refill_idx;
    logic             tag_hit;

    always_comb begin
        // NOTE: vectors get a default before the loop so no latch is inferred.
        hit_vec = '0;
        tag_vec = '0;
        for (int i = 0; i < NTLB; i++) begin
            hit_vec[i] = tlb[i].valid && (tlb[i].vpn == lookup_vpn) && (tlb[i].sup == lookup_sup)
                         && (tlb[i].glob || (tlb[i].asid == asid));
            tag_vec[i] = (tlb[i].sup == refill_sup) && (tlb[i].vpn == refill_vpn)
                         && (tlb[i].asid == refill_asid);
        end
    end

    assign hit        = |hit_vec;
    assign hit_idx    = lowest_index(hit_vec);
    assign hit_ppn    = hit ? tlb[hit_idx].ppn : '0;
    assign hit_perm   = hit & tlb[hit_idx].perm;
    assign tag_hit    = |tag_vec;
    assign refill_idx = tag_hit ? lowest_index(tag_vec) : rr_ptr;

    // NOTE: state is assigned with <= so every entry sees pre-edge values.
    // NOTE: only valid and tag fields are reset; ppn/perm are payload gated by valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int i = 0; i < NTLB; i++) begin
                tlb[i].valid <= 1'b0;
                tlb[i].sup   <= 1'b0;
                tlb[i].glob  <= 1'b0;
                tlb[i].asid  <= '0;
                tlb[i].vpn   <= '0;
            end
        end else if (inv_sup || inv_user) begin
            for (int i = 0; i < NTLB; i++) begin
                if ((tlb[i].sup ? inv_sup : inv_user)
                    && !(inv_asid_only && (tlb[i].glob || (tlb[i].asid != asid))))
                    tlb[i].valid <= 1'b0;
            end
        end else if (refill) begin
            tlb[refill_idx] <= '{valid: refill_valid, sup: refill_sup, glob: refill_glob,
                                 perm: refill_perm, asid: refill_asid, vpn: refill_vpn,
                                 ppn: refill_ppn};
            if (!tag_hit) rr_ptr <= rr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// vc16 MMU top: I and D TLB lookup, fault detection, fault register capture and
// the single software register used for refill and fault-state restore.
module mmu_tlb
    import mmu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              is_pc,
    input  logic              is_read,
    input  logic              is_write,
    input  logic              mmu_enable,
    input  logic              mmu_d_proxy,
    input  logic              supmode,
    input  logic [ASID_W-1:0] asid,
    input  logic [VA-1:WB]    pcv,
    input  logic [VA-1:WB]    addrv,
    output logic [PA-1:WB]    pcp,
    output logic [PA-1:WB]    addrp,
    output logic              mmu_miss_fault,
    output logic              mmu_prot_fault,
    input  logic              mmu_fault,
    input  logic [3:0]        inv_mmu,
    input  logic              inv_asid_only,
    input  logic              reg_write,
    input  logic [RV-1:0]     reg_data,
    output logic [RV-1:0]     reg_read
);

    fault_t fault_q;
    logic   sup_d;
    vpn_t   vpn_i, vpn_d;
    logic   i_hit, d_hit, i_perm, d_perm;
    ppn_t   i_ppn, d_ppn;
    logic   i_miss, d_miss;
    logic   do_inv, do_reg, refill_i, refill_d;
    logic   unused_reg_bits;

    assign sup_d  = supmode & ~(mmu_d_proxy & ~is_pc);
    assign vpn_i  = pcv[VA-1:PAGE_BITS];
    assign vpn_d  = addrv[VA-1:PAGE_BITS];

    // A committed fault blocks invalidate and register writes that cycle.
    assign do_inv   = ~mmu_fault & (|inv_mmu);
    assign do_reg   = ~mmu_fault & ~(|inv_mmu) & reg_write;
    assign refill_i = do_reg & reg_data[REG_ENTRY] & fault_q.ins;
    assign refill_d = do_reg & reg_data[REG_ENTRY] & ~fault_q.ins;

    assign unused_reg_bits = ^(reg_data >> (REG_ASID_LSB + ASID_W));

    tlb_bank u_itlb (
        .clk           (clk),
        .reset         (reset),
        .lookup_vpn    (vpn_i),
        .lookup_sup    (supmode),
        .asid          (asid),
        .hit           (i_hit),
        .hit_ppn       (i_ppn),
        .hit_perm      (i_perm),
        .inv_sup       (do_inv & inv_mmu[INV_SI]),
        .inv_user      (do_inv & inv_mmu[INV_UI]),
        .inv_asid_only (inv_asid_only),
        .refill        (refill_i),
        .refill_sup    (fault_q.sup),
        .refill_vpn    (fault_q.vpn),
        .refill_asid   (fault_q.asid),
        .refill_ppn    (reg_data[RV-1 -: PPN_W]),
        .refill_valid  (reg_data[REG_VALID]),
        .refill_perm   (reg_data[REG_PERM]),
        .refill_glob   (reg_data[REG_GLOBAL])
    );

    tlb_bank u_dtlb (
        .clk           (clk),
        .reset         (reset),
        .lookup_vpn    (vpn_d),
        .lookup_sup    (sup_d),
        .asid          (asid),
        .hit           (d_hit),
        .hit_ppn       (d_ppn),
        .hit_perm      (d_perm),
        .inv_sup       (do_inv & inv_mmu[INV_SD]),
        .inv_user      (do_inv & inv_mmu[INV_UD]),
        .inv_asid_only (inv_asid_only),
        .refill        (refill_d),
        .refill_sup    (fault_q.sup),
        .refill_vpn    (fault_q.vpn),
        .refill_asid   (fault_q.asid),
        .refill_ppn    (reg_data[RV-1 -: PPN_W]),
        .refill_valid  (reg_data[REG_VALID]),
        .refill_perm   (reg_data[REG_PERM]),
        .refill_glob   (reg_data[REG_GLOBAL])
    );

    always_comb begin
        pcp   = '0;
        addrp = '0;
        if (mmu_enable) begin
            pcp   = {i_ppn, pcv[PAGE_BITS-1:WB]};
            addrp = {d_ppn, addrv[PAGE_BITS-1:WB]};
        end else begin
            pcp[VA-1:WB]   = pcv;
            addrp[VA-1:WB] = addrv;
        end
    end

    assign i_miss         = is_pc & ~i_hit;
    assign d_miss         = (is_read | is_write) & ~d_hit;
    assign mmu_miss_fault = mmu_enable & (i_miss | d_miss);
    assign mmu_prot_fault = mmu_enable & ((is_write & d_hit & ~d_perm) | (is_pc & i_hit & ~i_perm));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= '0;
        end else if (mmu_fault) begin
            fault_q <= '{vpn: i_miss ? vpn_i : vpn_d, asid: asid, ins: is_pc,
                         sup: sup_d, miss: mmu_miss_fault};
        end else if (do_reg && !reg_data[REG_ENTRY]) begin
            fault_q <= '{vpn: reg_data[VA-1:PAGE_BITS], asid: reg_data[REG_ASID_LSB +: ASID_W],
                         ins: reg_data[REG_INS], sup: reg_data[REG_SUP], miss: reg_data[REG_TYPE]};
        end
    end

    always_comb begin
        reg_read                           = '0;
        reg_read[RV-1 -: VPN_W]            = fault_q.vpn;
        reg_read[REG_ASID_LSB +: ASID_W]   = fault_q.asid;
        reg_read[REG_INS]                  = fault_q.ins;
        reg_read[REG_SUP]                  = fault_q.sup;
        reg_read[REG_TYPE]                 = fault_q.miss;
    end

endmodule
